// File: rtl/fetch_instruction_pkg.sv
// Shared definitions for the instruction-fetch stage: opcodes, the NOP word
// and the fetch FSM state encoding.
package fetch_instruction_pkg;

  localparam logic [4:0]  OPC_HALT = 5'b00000;
  localparam logic [4:0]  OPC_NOP  = 5'b00001;
  localparam logic [15:0] NOP_WORD = {OPC_NOP, 11'b0};

  typedef enum logic [1:0] {
    ST_READY  = 2'd0,
    ST_WAIT   = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_HALTED = 2'd3
  } fetch_state_e;

  function automatic logic isHalt(input logic [15:0] word);
    return word[15:11] == OPC_HALT;
  endfunction

endpackage

// File: rtl/fetch_instruction_reg16.sv
// 16-bit register with synchronous active-low reset and load enable.
module reg16 #(
  parameter logic [15:0] RESET_VAL = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_i,
  input  logic [15:0] d_i,
  output logic [15:0] q_o
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      q_o <= RESET_VAL;
    end else if (en_i) begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/fetch_instruction.sv
// Instruction-fetch stage: owns the PC, issues one memory read at a time and
// holds the fetched word for decode, handling redirects and HALT.
module fetch_instruction
  import fetch_instruction_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imemReq,
  output logic [15:0] imemAddr,
  input  logic        imemRdy,
  input  logic [15:0] imemData,
  input  logic        redirectEn,
  input  logic [15:0] redirectPC,
  input  logic        decodeStall,
  output logic        instrValid,
  output logic [15:0] instruction,
  output logic [15:0] pcPlus2,
  output logic        halted,
  output logic        err
);

  fetch_state_e state_q, state_d;
  logic         instrValid_q, instrValid_d;
  logic         err_q, err_d;
  logic [15:0]  pc_q, pc_d;
  logic         pcEn;
  logic [15:0]  pcNext;
  logic         redirectAct;
  logic         outFree;
  logic         latchResp;
  logic         reqComb;

  // Once halted the stage is frozen until reset, so redirects lose their effect.
  assign redirectAct = redirectEn && (state_q != ST_HALTED);
  assign outFree     = !instrValid_q || !decodeStall;
  assign latchResp   = (state_q == ST_WAIT) && imemRdy && !redirectAct;
  assign pcNext      = pc_q + 16'd2;

  always_comb begin
    state_d = state_q;
    reqComb = 1'b0;
    unique case (state_q)
      ST_READY: begin
        if (!redirectAct && outFree) begin
          reqComb = 1'b1;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (redirectAct) begin
          state_d = imemRdy ? ST_READY : ST_DRAIN;
        end else if (imemRdy) begin
          state_d = isHalt(imemData) ? ST_HALTED : ST_READY;
        end
      end
      ST_DRAIN: begin
        if (imemRdy) begin
          state_d = ST_READY;
        end
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
      default: state_d = ST_READY;
    endcase
  end

  // Redirect wins over a same-cycle response; misaligned targets are forced even.
  always_comb begin
    pc_d         = pcNext;
    pcEn         = 1'b0;
    instrValid_d = instrValid_q;
    err_d        = err_q;
    if (instrValid_q && !decodeStall) begin
      instrValid_d = 1'b0;
    end
    if (latchResp) begin
      pcEn         = 1'b1;
      instrValid_d = 1'b1;
    end
    if (redirectAct) begin
      pc_d         = {redirectPC[15:1], 1'b0};
      pcEn         = 1'b1;
      instrValid_d = 1'b0;
      err_d        = err_q | redirectPC[0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_READY;
      instrValid_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      instrValid_q <= instrValid_d;
      err_q        <= err_d;
    end
  end

  reg16 #(.RESET_VAL(RESET_PC)) u_pcReg (
    .clk  (clk),
    .rst  (rst),
    .en_i (pcEn),
    .d_i  (pc_d),
    .q_o  (pc_q)
  );

  reg16 #(.RESET_VAL(NOP_WORD)) u_instrReg (
    .clk  (clk),
    .rst  (rst),
    .en_i (latchResp),
    .d_i  (imemData),
    .q_o  (instruction)
  );

  reg16 #(.RESET_VAL(16'h0000)) u_pcPlus2Reg (
    .clk  (clk),
    .rst  (rst),
    .en_i (latchResp),
    .d_i  (pcNext),
    .q_o  (pcPlus2)
  );

  assign imemReq    = rst && reqComb;
  assign imemAddr   = pc_q;
  assign instrValid = instrValid_q;
  assign halted     = (state_q == ST_HALTED);
  assign err        = err_q;

endmodule
